// File: rtl/hash_request_frontend.sv
// Request front end for the cuckoo hash_table: buffers client requests, issues them one at a time,
// waits the table latency and returns a held response. `define HASH_FRONTEND_STATS_EN adds counters.
module hash_request_frontend #(
  parameter int KEY_WIDTH     = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int TABLE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [KEY_WIDTH-1:0]  req_key_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_op_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [2:0]            resp_status_o,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            delete_write_read_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  no_deletion_target_i,
  input  logic                  no_write_space_i,
  input  logic                  no_element_found_i,
  output logic [1:0]            dbg_state_o
`ifdef HASH_FRONTEND_STATS_EN
  ,
  output logic [15:0]           stat_ops_o,
  output logic [15:0]           stat_fail_o,
  output logic [15:0]           stat_drop_o
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid stays asserted with stable payload until that edge, ready may change freely.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TABLE_LATENCY > 1) ? $clog2(TABLE_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_nx;

  logic [1:0]            fifo_op   [FIFO_DEPTH];
  logic [KEY_WIDTH-1:0]  fifo_key  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty, push, pop;

  logic [1:0]            op_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         wait_cnt;
  logic                  capture, resp_fire;
  logic [2:0]            status_nx;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && req_ready_o && (req_op_i != 2'b00);
  assign pop         = !fifo_empty &&
                       ((state == S_IDLE) || ((state == S_RESP) && resp_ready_i));
  assign capture     = (state == S_WAIT) && (wait_cnt == '0);
  assign resp_fire   = (state == S_RESP) && resp_ready_i;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]]   <= req_op_i;
      fifo_key[wr_ptr[AW-1:0]]  <= req_key_i;
      fifo_data[wr_ptr[AW-1:0]] <= req_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nx = S_RESP;
      S_RESP:  if (resp_ready_i) state_nx = fifo_empty ? S_IDLE : S_ISSUE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs; the table sees a non-zero opcode only during ISSUE
  always_comb begin
    delete_write_read_o = (state == S_ISSUE) ? op_q : 2'b00;
    resp_valid_o        = (state == S_RESP);
    dbg_state_o         = state;
  end

  assign key_o  = key_q;
  assign data_o = data_q;

  // Only the flag meaningful for the completed op is reported.
  always_comb begin
    status_nx = 3'b000;
    case (op_q)
      2'b01:   status_nx = {1'b0, no_write_space_i, 1'b0};
      2'b10:   status_nx = {2'b00, no_element_found_i};
      2'b11:   status_nx = {no_deletion_target_i, 2'b00};
      default: status_nx = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= 2'b00;
      key_q         <= '0;
      data_q        <= '0;
      wait_cnt      <= '0;
      resp_op_o     <= 2'b00;
      resp_data_o   <= '0;
      resp_status_o <= 3'b000;
    end else begin
      if (pop) begin
        op_q   <= fifo_op[rd_ptr[AW-1:0]];
        key_q  <= fifo_key[rd_ptr[AW-1:0]];
        data_q <= fifo_data[rd_ptr[AW-1:0]];
      end
      if (state == S_ISSUE)
        wait_cnt <= CW'(TABLE_LATENCY - 1);
      else if ((state == S_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;
      if (capture) begin
        resp_op_o     <= op_q;
        resp_data_o   <= (op_q == 2'b10) ? read_data_i : '0;
        resp_status_o <= status_nx;
      end
    end
  end

`ifdef HASH_FRONTEND_STATS_EN
  logic drop;
  assign drop = req_valid_i && req_ready_o && (req_op_i == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_o  <= '0;
      stat_fail_o <= '0;
      stat_drop_o <= '0;
    end else begin
      if (resp_fire && (stat_ops_o != 16'hFFFF))
        stat_ops_o <= stat_ops_o + 16'd1;
      if (resp_fire && (resp_status_o != 3'b000) && (stat_fail_o != 16'hFFFF))
        stat_fail_o <= stat_fail_o + 16'd1;
      if (drop && (stat_drop_o != 16'hFFFF))
        stat_drop_o <= stat_drop_o + 16'd1;
    end
  end
`endif

endmodule
